rect_fill: RTL and testbench
============================

# rect_fill

Parametrised rectangle rasteriser for the virtual-pixel framebuffer. Given a screen-space origin, a size in virtual pixels, a colour and a mode, it streams one framebuffer write per clock (filled or outline-only), clipping against the screen edge, then holds `finished` until the requester releases `draw_en`. It sits between the game/draw controller and the framebuffer memory write port, replacing single-pixel draws for block graphics.

## Interface

- `VGA_WIDTH`, 640: screen width in screen pixels.
- `VGA_HEIGHT`, 480: screen height in screen pixels.
- `PIXEL_VIRTUAL_SIZE`, 4: screen pixels per virtual pixel edge (power of two).
- `ADDR_WIDTH`, 15: framebuffer address width.
- `COLOR_WIDTH`, 24: colour word width.
- `SIZE_WIDTH`, 8: width of `rect_w`/`rect_h`.
- Derived: VW = VGA_WIDTH/PIXEL_VIRTUAL_SIZE (160); VH = VGA_HEIGHT/PIXEL_VIRTUAL_SIZE (120).

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `draw_en`  in  1  level request; held high for the whole operation.
- `startx`  in  10  origin x, screen pixels.
- `starty`  in  10  origin y, screen pixels.
- `rect_w`  in  SIZE_WIDTH  width, virtual pixels.
- `rect_h`  in  SIZE_WIDTH  height, virtual pixels.
- `mode`  in  1  0 = filled, 1 = outline only.
- `color`  in  COLOR_WIDTH  fill colour.
- `busy`  out  1  high in SETUP and FILL.
- `finished`  out  1  high in DONE.
- `write_en`  out  1  framebuffer write strobe.
- `write_mem_address`  out  ADDR_WIDTH  framebuffer address.
- `data`  out  COLOR_WIDTH  write data.
- `x`, `y`  out  10 each  screen coordinate of the current virtual pixel (v*PIXEL_VIRTUAL_SIZE).

## Operation

- States: IDLE, SETUP, FILL, DONE.
- IDLE: on `draw_en`=1, latch vx0 = startx/PVS, vy0 = starty/PVS, rect_w, rect_h, mode, color; go SETUP.
- SETUP: clipped extents we = min(rect_w, VW−vx0), he = min(rect_h, VH−vy0); either is 0 if vx0 ≥ VW or vy0 ≥ VH. If we=0 or he=0 go DONE, else load vx=vx0, vy=vy0, go FILL.
- FILL: one virtual pixel per cycle, vy inner loop (consecutive addresses), vx outer. Address = vx*VH + vy, computed at full width then truncated to ADDR_WIDTH. After the last pixel (vx=vx0+we−1, vy=vy0+he−1) go DONE.
- write_en = 1 for every visited pixel in mode 0; in mode 1 only when vx∈{vx0, vx0+rect_w−1} or vy∈{vy0, vy0+rect_h−1}. Borders refer to the unclipped rectangle, so clipped edges are not drawn. Skipped pixels still consume a cycle.
- `data` = latched colour; input changes after latch are ignored.
- DONE: `finished`=1 while `draw_en`=1; on `draw_en`=0 go IDLE.
- Abort: `draw_en`=0 in SETUP or FILL goes to IDLE next edge; no further writes; `finished` stays 0.
- Reset (any time): state IDLE; all outputs 0 (`busy`, `finished`, `write_en`, `write_mem_address`, `data`, `x`, `y`). The in-flight write is dropped.

## Timing

- All outputs are registered.
- Edge k: IDLE samples `draw_en`=1. Edge k+1: SETUP → FILL.
- Pixel i (0-based) is presented on the outputs after edge k+2+i. Valid pixels: N = we*he.
- Exactly N cycles of FILL, with `write_en` high on all of them (mode 0) or a subset (mode 1).
- `finished` rises after edge k+2+N; for an empty rectangle it rises after edge k+2.
- `write_en` is low outside FILL. Back-to-back requests need ≥1 cycle of `draw_en`=0 between them.

## Test plan

- Reset: assert `rst`=0 mid-FILL → all outputs 0 immediately; after release, state IDLE and `write_en`=0.
- Fill: startx=8, starty=12, w=3, h=2, color=24'hFF0000, mode 0 → 6 writes at 243, 244, 363, 364, 483, 484 with data FF0000; `finished` after edge k+8.
- Clip: startx=632, starty=0, w=5, h=1 → exactly 2 writes at 18960 and 19080; `finished` after edge k+4.
- Empty: startx=640 (or w=0) → no `write_en`; `finished`=1 after edge k+2; drops one edge after `draw_en`=0.
- Outline: origin (0,0), w=3, h=3, mode 1 → 9 FILL cycles, 8 writes; address 121 skipped.
- Abort: fill w=4, h=4; drop `draw_en` after 2 writes → IDLE next edge, no further writes, `finished` never 1; new request then runs normally.

Source files
------------

// File: rtl/rect_fill_if.sv
// rect_fill_if: draw request from the controller and the framebuffer write
// stream produced by the rasteriser.
interface rect_fill_if #(
    parameter int ADDR_WIDTH  = 15,
    parameter int COLOR_WIDTH = 24,
    parameter int SIZE_WIDTH  = 8
);
    logic                   draw_en;
    logic [9:0]             startx;
    logic [9:0]             starty;
    logic [SIZE_WIDTH-1:0]  rect_w;
    logic [SIZE_WIDTH-1:0]  rect_h;
    logic                   mode;
    logic [COLOR_WIDTH-1:0] color;
    logic                   busy;
    logic                   finished;
    logic                   write_en;
    logic [ADDR_WIDTH-1:0]  write_mem_address;
    logic [COLOR_WIDTH-1:0] data;
    logic [9:0]             x;
    logic [9:0]             y;

    modport master (
        output draw_en, startx, starty, rect_w, rect_h, mode, color,
        input  busy, finished, write_en, write_mem_address, data, x, y
    );

    modport slave (
        input  draw_en, startx, starty, rect_w, rect_h, mode, color,
        output busy, finished, write_en, write_mem_address, data, x, y
    );
endinterface

// File: rtl/rect_fill.sv
// rect_fill: rasterises a filled or outlined rectangle in virtual pixels,
// one framebuffer write per clock, clipped at the screen edge.
module rect_fill #(
    parameter int VGA_WIDTH          = 640,
    parameter int VGA_HEIGHT         = 480,
    parameter int PIXEL_VIRTUAL_SIZE = 4,
    parameter int ADDR_WIDTH         = 15,
    parameter int COLOR_WIDTH        = 24,
    parameter int SIZE_WIDTH         = 8
) (
    input logic        clk,
    input logic        rst,
    rect_fill_if.slave bus
);
    localparam int VW = VGA_WIDTH / PIXEL_VIRTUAL_SIZE;
    localparam int VH = VGA_HEIGHT / PIXEL_VIRTUAL_SIZE;
    localparam int CW = 16;

    typedef enum logic [1:0] {IDLE, SETUP, FILL, DONE} state_t;

    state_t                 state;
    logic [CW-1:0]          vx0, vy0, rw, rh, vx, vy, vx_last, vy_last;
    logic [CW-1:0]          we_c, he_c;
    logic                   md;
    logic [COLOR_WIDTH-1:0] col;
    logic                   border;

    // outline borders use the unclipped extents so clipped edges stay open
    always_comb begin
        we_c = (vx0 >= CW'(VW)) ? '0 : (rw < CW'(VW) - vx0) ? rw : CW'(VW) - vx0;
        he_c = (vy0 >= CW'(VH)) ? '0 : (rh < CW'(VH) - vy0) ? rh : CW'(VH) - vy0;
        border = !md || vx == vx0 || vx == vx0 + rw - 1'b1 || vy == vy0 || vy == vy0 + rh - 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state                 <= IDLE;
            vx0                   <= '0;
            vy0                   <= '0;
            rw                    <= '0;
            rh                    <= '0;
            vx                    <= '0;
            vy                    <= '0;
            vx_last               <= '0;
            vy_last               <= '0;
            md                    <= 1'b0;
            col                   <= '0;
            bus.busy              <= 1'b0;
            bus.finished          <= 1'b0;
            bus.write_en          <= 1'b0;
            bus.write_mem_address <= '0;
            bus.data              <= '0;
            bus.x                 <= '0;
            bus.y                 <= '0;
        end else begin
            bus.write_en <= 1'b0;
            bus.busy     <= (state == SETUP || state == FILL) && bus.draw_en;
            bus.finished <= state == DONE && bus.draw_en;
            case (state)
                IDLE: if (bus.draw_en) begin
                    vx0   <= CW'(bus.startx / 10'(PIXEL_VIRTUAL_SIZE));
                    vy0   <= CW'(bus.starty / 10'(PIXEL_VIRTUAL_SIZE));
                    rw    <= CW'(bus.rect_w);
                    rh    <= CW'(bus.rect_h);
                    md    <= bus.mode;
                    col   <= bus.color;
                    state <= SETUP;
                end
                SETUP: if (!bus.draw_en) state <= IDLE;
                else if (we_c == '0 || he_c == '0) state <= DONE;
                else begin
                    vx      <= vx0;
                    vy      <= vy0;
                    vx_last <= vx0 + we_c - 1'b1;
                    vy_last <= vy0 + he_c - 1'b1;
                    state   <= FILL;
                end
                FILL: if (!bus.draw_en) state <= IDLE;
                else begin
                    bus.write_en          <= border;
                    bus.write_mem_address <= ADDR_WIDTH'(32'(vx) * VH + 32'(vy));
                    bus.data              <= col;
                    bus.x                 <= 10'(32'(vx) * PIXEL_VIRTUAL_SIZE);
                    bus.y                 <= 10'(32'(vy) * PIXEL_VIRTUAL_SIZE);
                    if (vy == vy_last) begin
                        vy <= vy0;
                        if (vx == vx_last) state <= DONE;
                        else vx <= vx + 1'b1;
                    end else vy <= vy + 1'b1;
                end
                DONE: if (!bus.draw_en) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rect_fill.sv
// tb_rect_fill: table vectors, randomized requests against a pixel-list model,
// plus reset and abort sequences.
module tb_rect_fill;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;

    rect_fill_if #(.ADDR_WIDTH(15), .COLOR_WIDTH(24), .SIZE_WIDTH(8)) bus ();

    rect_fill dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic wr;
        int   addr;
        int   x;
        int   y;
    } pix_t;

    typedef struct {
        int          sx, sy, w, h, m;
        logic [23:0] c;
        int          n, fa, la, fj;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic model(input int sx, sy, w, h, m, output pix_t q[$]);
        int vx0, vy0, we, he;
        pix_t p;
        q = {};
        vx0 = sx / 4;
        vy0 = sy / 4;
        we = (vx0 >= 160) ? 0 : ((w < 160 - vx0) ? w : 160 - vx0);
        he = (vy0 >= 120) ? 0 : ((h < 120 - vy0) ? h : 120 - vy0);
        for (int vx = vx0; vx < vx0 + we; vx++)
            for (int vy = vy0; vy < vy0 + he; vy++) begin
                p.wr = m == 0 || vx == vx0 || vx == vx0 + w - 1 || vy == vy0 || vy == vy0 + h - 1;
                p.addr = (vx * 120 + vy) % 32768;
                p.x = vx * 4;
                p.y = vy * 4;
                q.push_back(p);
            end
    endtask

    task automatic run_rect(input int sx, sy, w, h, m, input logic [23:0] c,
                            output int nw, output int fa, output int la, output int fj);
        pix_t q[$];
        int   n_exp_wr;
        int   i;
        model(sx, sy, w, h, m, q);
        n_exp_wr = 0;
        foreach (q[k]) if (q[k].wr) n_exp_wr++;
        nw = 0; fa = -1; la = -1; fj = -1;
        @(negedge clk);
        bus.startx = 10'(sx); bus.starty = 10'(sy);
        bus.rect_w = 8'(w); bus.rect_h = 8'(h);
        bus.mode = 1'(m); bus.color = c;
        bus.draw_en = 1'b1;
        for (int j = 0; j < 20000; j++) begin
            @(negedge clk);
            if (j == 1) begin
                chk("busy_setup", 32'(bus.busy), 1);
                bus.startx = 10'($urandom); bus.starty = 10'($urandom);
                bus.rect_w = 8'($urandom); bus.rect_h = 8'($urandom);
                bus.mode = 1'($urandom); bus.color = 24'($urandom);
            end
            if (bus.write_en) begin
                i = j - 2;
                if (i < 0 || i >= q.size()) chk("write_slot", 32'(j), 32'(2 + q.size()));
                else begin
                    chk("write_allowed", 32'(bus.write_en), 32'(q[i].wr));
                    chk("addr", 32'(bus.write_mem_address), 32'(q[i].addr));
                    chk("data", 32'(bus.data), 32'(c));
                    chk("xy", {16'(bus.x), 16'(bus.y)}, {16'(q[i].x), 16'(q[i].y)});
                end
                if (nw == 0) fa = int'(bus.write_mem_address);
                la = int'(bus.write_mem_address);
                nw++;
            end
            if (bus.finished) begin
                fj = j;
                break;
            end
        end
        chk("finish_edge", 32'(fj), 32'(q.size() + 2));
        chk("write_count", 32'(nw), 32'(n_exp_wr));
        chk("busy_done", 32'(bus.busy), 0);
        chk("we_done", 32'(bus.write_en), 0);
        bus.draw_en = 1'b0;
        @(negedge clk);
        chk("finished_drop", 32'(bus.finished), 0);
    endtask

    vec_t tbl[10];

    initial begin
        int nw, fa, la, fj, sx, sy, w, h, m;
        logic [23:0] c;
        tbl[0] = '{8, 12, 3, 2, 0, 24'hFF0000, 6, 243, 484, 8};
        tbl[1] = '{632, 0, 5, 1, 0, 24'h00FF00, 2, 18960, 19080, 4};
        tbl[2] = '{640, 0, 5, 5, 0, 24'h123456, 0, -1, -1, 2};
        tbl[3] = '{0, 0, 0, 5, 0, 24'h123456, 0, -1, -1, 2};
        tbl[4] = '{0, 0, 3, 3, 1, 24'h0000FF, 8, 0, 242, 11};
        tbl[5] = '{636, 476, 3, 3, 1, 24'hABCDEF, 1, 19199, 19199, 3};
        tbl[6] = '{632, 0, 4, 3, 1, 24'h777777, 5, 18960, 19082, 8};
        tbl[7] = '{0, 480, 2, 2, 0, 24'h010203, 0, -1, -1, 2};
        tbl[8] = '{4, 4, 1, 1, 0, 24'hFFFFFF, 1, 121, 121, 3};
        tbl[9] = '{0, 0, 255, 255, 0, 24'h5A5A5A, 19200, 0, 19199, 19202};

        bus.draw_en = 1'b0; bus.startx = '0; bus.starty = '0;
        bus.rect_w = '0; bus.rect_h = '0; bus.mode = 1'b0; bus.color = '0;
        repeat (3) @(negedge clk);
        chk("rst_outputs", {27'(bus.write_mem_address), bus.busy, bus.finished, bus.write_en, 2'b00},
            32'd0);
        chk("rst_data_xy", {8'(bus.data), 12'(bus.x), 12'(bus.y)}, 32'd0);
        rst = 1'b1;

        for (int t = 0; t < 10; t++) begin
            run_rect(tbl[t].sx, tbl[t].sy, tbl[t].w, tbl[t].h, tbl[t].m, tbl[t].c, nw, fa, la, fj);
            chk("tbl_count", 32'(nw), 32'(tbl[t].n));
            chk("tbl_first", 32'(fa), 32'(tbl[t].fa));
            chk("tbl_last", 32'(la), 32'(tbl[t].la));
            chk("tbl_finish", 32'(fj), 32'(tbl[t].fj));
        end

        for (int t = 0; t < 25; t++) begin
            sx = int'($urandom_range(0, 660));
            sy = int'($urandom_range(0, 500));
            w = int'($urandom_range(0, 20));
            h = int'($urandom_range(0, 20));
            m = int'($urandom_range(0, 1));
            c = 24'($urandom);
            run_rect(sx, sy, w, h, m, c, nw, fa, la, fj);
        end

        // reset mid-fill
        @(negedge clk);
        bus.startx = 10'd0; bus.starty = 10'd0; bus.rect_w = 8'd4; bus.rect_h = 8'd4;
        bus.mode = 1'b0; bus.color = 24'hC0FFEE; bus.draw_en = 1'b1;
        repeat (5) @(negedge clk);
        chk("pre_rst_we", 32'(bus.write_en), 1);
        #2 rst = 1'b0; bus.draw_en = 1'b0;
        #1;
        chk("async_rst_ctl", {bus.busy, bus.finished, bus.write_en}, 0);
        chk("async_rst_addr", 32'(bus.write_mem_address), 0);
        chk("async_rst_data", 32'(bus.data), 0);
        chk("async_rst_xy", {16'(bus.x), 16'(bus.y)}, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_idle", {bus.busy, bus.finished, bus.write_en}, 0);
        run_rect(8, 12, 3, 2, 0, 24'hFF0000, nw, fa, la, fj);
        chk("post_rst_count", 32'(nw), 6);

        // abort after two writes
        @(negedge clk);
        bus.startx = 10'd0; bus.starty = 10'd0; bus.rect_w = 8'd4; bus.rect_h = 8'd4;
        bus.mode = 1'b0; bus.color = 24'h00AA00; bus.draw_en = 1'b1;
        nw = 0;
        for (int j = 0; j < 50 && nw < 2; j++) begin
            @(negedge clk);
            if (bus.write_en) nw++;
        end
        chk("abort_seen", 32'(nw), 2);
        bus.draw_en = 1'b0;
        fj = 0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (bus.write_en) nw++;
            if (bus.finished) fj++;
        end
        chk("abort_writes", 32'(nw), 2);
        chk("abort_finished", 32'(fj), 0);
        chk("abort_busy", 32'(bus.busy), 0);
        run_rect(0, 0, 3, 3, 1, 24'h0000FF, nw, fa, la, fj);
        chk("after_abort_count", 32'(nw), 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
